// File: rtl/keypad_scanner_pkg.sv
// ----------------------------------------------------------------------------
// keypad_scanner_pkg
//   Shared constants for the keypad front end of the safe: special key codes,
//   scanner FSM state encoding, the row strobe reset pattern and a helper that
//   decides whether a column sample identifies exactly one key.
// ----------------------------------------------------------------------------
package keypad_scanner_pkg;

    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_SHARP = 4'hB;

    localparam logic [3:0] ROW_RESET = 4'b0001;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Exactly one column high; none or several high means "no key".
    function automatic logic is_single_col(input logic [2:0] cols);
        return (cols == 3'b001) || (cols == 3'b010) || (cols == 3'b100);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a small bus of slow, independently changing
//   level signals (keypad columns and similar board inputs).
// Ports:
//   clk      - destination clock
//   reset_n  - asynchronous active-low clear of both flop stages
//   d        - asynchronous input bus
//   q        - synchronized output bus, two clocks behind d
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
//   Drives a 4x3 keypad matrix one row at a time, samples the three columns
//   at the end of each row dwell, debounces the result and reports one clean
//   key event per physical press.
// Ports:
//   clk, reset_n            - system clock, asynchronous active-low reset
//   col1..col3              - keypad columns, active-high, asynchronous
//   row1..row4              - one-hot row strobes, active-high, registered
//   key_code                - last accepted key (0-9, A = star, B = sharp)
//   key_valid               - one-clock pulse on press acceptance
//   key_held                - high from acceptance until release acceptance
//   star_held, sharp_held   - key_held qualified by the star / sharp code
// ----------------------------------------------------------------------------
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       col1,
    input  logic       col2,
    input  logic       col3,
    output logic       row1,
    output logic       row2,
    output logic       row3,
    output logic       row4,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       star_held,
    output logic       sharp_held
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    // Counters stop one short of DEBOUNCE_CNT: the final matching sample
    // triggers the transition, so a $clog2-wide counter is always enough.
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CNT - 1);

    logic [2:0]         col_sync;
    logic [DWELL_W-1:0] dwell;
    logic               sample_tick;
    logic               valid_sample;
    logic [3:0]         rows;
    logic [3:0]         rows_next;
    scan_state_t        state;
    logic [2:0]         cand_col;
    logic [CNT_W-1:0]   match_cnt;
    logic [CNT_W-1:0]   rel_cnt;
    logic [3:0]         mapped_code;

    sync_2ff #(.WIDTH(3)) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({col3, col2, col1}),
        .q       (col_sync)
    );

    assign sample_tick  = (dwell == DWELL_LAST);
    assign valid_sample = is_single_col(col_sync);
    assign rows_next    = {rows[2:0], rows[3]};

    assign row1 = rows[0];
    assign row2 = rows[1];
    assign row3 = rows[2];
    assign row4 = rows[3];

    assign star_held  = key_held && (key_code == KEY_STAR);
    assign sharp_held = key_held && (key_code == KEY_SHARP);

    // The row register is frozen while a candidate is pending or held, so it
    // doubles as the candidate row; acceptance only happens on a sample equal
    // to the candidate column, so the live sample gives the candidate column.
    always_comb begin
        mapped_code = 4'h0;
        case ({rows, col_sync})
            {4'b0001, 3'b001}: mapped_code = 4'h1;
            {4'b0001, 3'b010}: mapped_code = 4'h2;
            {4'b0001, 3'b100}: mapped_code = 4'h3;
            {4'b0010, 3'b001}: mapped_code = 4'h4;
            {4'b0010, 3'b010}: mapped_code = 4'h5;
            {4'b0010, 3'b100}: mapped_code = 4'h6;
            {4'b0100, 3'b001}: mapped_code = 4'h7;
            {4'b0100, 3'b010}: mapped_code = 4'h8;
            {4'b0100, 3'b100}: mapped_code = 4'h9;
            {4'b1000, 3'b001}: mapped_code = KEY_STAR;
            {4'b1000, 3'b010}: mapped_code = 4'h0;
            {4'b1000, 3'b100}: mapped_code = KEY_SHARP;
            default:           mapped_code = 4'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell     <= '0;
            rows      <= ROW_RESET;
            state     <= SCAN;
            cand_col  <= 3'b000;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;

            if (sample_tick) begin
                dwell <= '0;
            end else begin
                dwell <= dwell + 1'b1;
            end

            if (sample_tick) begin
                case (state)
                    SCAN: begin
                        if (valid_sample) begin
                            cand_col <= col_sync;
                            if (DEBOUNCE_CNT == 1) begin
                                key_code  <= mapped_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                match_cnt <= '0;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                match_cnt <= CNT_W'(1);
                                state     <= DEBOUNCE;
                            end
                        end else begin
                            rows <= rows_next;
                        end
                    end

                    DEBOUNCE: begin
                        if (col_sync == cand_col) begin
                            if (match_cnt == CNT_LAST) begin
                                key_code  <= mapped_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                match_cnt <= '0;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            state     <= SCAN;
                            rows      <= rows_next;
                        end
                    end

                    HELD: begin
                        // Only the candidate column matters; other keys on
                        // the same row neither extend nor end the hold.
                        if ((col_sync & cand_col) == 3'b000) begin
                            if (rel_cnt == CNT_LAST) begin
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                state    <= SCAN;
                                rows     <= rows_next;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner with a short dwell and debounce. A
//   matrix model turns pressed keys into column levels from the driven row;
//   expected key codes are queued when a press is applied and popped when
//   the scanner reports key_valid.
// ----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    // Matrix key indices: row r (0..3), column c (0..2) -> r*3 + c.
    localparam int IDX_KEY3  = 2;
    localparam int IDX_KEY5  = 4;
    localparam int IDX_KEY7  = 6;
    localparam int IDX_KEY8  = 7;
    localparam int IDX_KEY9  = 8;
    localparam int IDX_STAR  = 9;
    localparam int IDX_ZERO  = 10;
    localparam int IDX_SHARP = 11;

    logic       clk;
    logic       reset_n;
    logic       col1;
    logic       col2;
    logic       col3;
    logic       row1;
    logic       row2;
    logic       row3;
    logic       row4;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       star_held;
    logic       sharp_held;

    logic [11:0] pressed;
    logic        glitch3;
    logic [3:0]  rows_vec;
    logic [2:0]  matrix_cols;

    int          compared;
    int          mismatched;
    int          valid_count;
    logic [3:0]  exp_q[$];

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .col1       (col1),
        .col2       (col2),
        .col3       (col3),
        .row1       (row1),
        .row2       (row2),
        .row3       (row3),
        .row4       (row4),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .star_held  (star_held),
        .sharp_held (sharp_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rows_vec = {row4, row3, row2, row1};

    // A column is high when any pressed key on the currently driven row
    // connects it.
    always_comb begin
        matrix_cols = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (rows_vec[r]) begin
                matrix_cols = matrix_cols | pressed[r*3 +: 3];
            end
        end
    end

    assign col1 = matrix_cols[0];
    assign col2 = matrix_cols[1];
    assign col3 = matrix_cols[2] | glitch3;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic level);
        pressed[idx] = level;
    endtask

    task automatic waitValid(input int bound, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) found = 1'b1;
        end
        checkOutput({tag, "_valid_seen"}, 32'(found), 32'd1);
    endtask

    task automatic waitRelease(input int bound, input string tag, output int clocks);
        logic released;
        released = 1'b0;
        clocks   = 0;
        for (int i = 0; i < bound && !released; i++) begin
            @(negedge clk);
            clocks++;
            if (key_held === 1'b0) released = 1'b1;
        end
        checkOutput({tag, "_release_seen"}, 32'(released), 32'd1);
    endtask

    task automatic waitRow(input logic [3:0] target, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            if (rows_vec === target) hit = 1'b1;
        end
        checkOutput({tag, "_row_reached"}, 32'(hit), 32'd1);
    endtask

    // Scoreboard side: every accepted press must have been expected.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && key_valid === 1'b1) begin
            valid_count++;
            checkOutput("key_valid_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                checkOutput("key_code_on_valid", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int t;
        logic [3:0] exp_row;

        compared    = 0;
        mismatched  = 0;
        valid_count = 0;
        pressed     = 12'b0;
        glitch3     = 1'b0;
        reset_n     = 1'b0;

        // Reset state and idle scanning.
        repeat (3) @(negedge clk);
        checkOutput("reset_rows", 32'(rows_vec), 32'h1);
        checkOutput("reset_key_code", 32'(key_code), 32'h0);
        checkOutput("reset_key_valid", 32'(key_valid), 32'h0);
        checkOutput("reset_key_held", 32'(key_held), 32'h0);
        reset_n = 1'b1;
        $display("[TB] idle scan");
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            exp_row = 4'(1 << ((i / 4) % 4));
            checkOutput("idle_scan_row", 32'(rows_vec), 32'(exp_row));
        end

        // Key 5: one event, held through a long press, released after three
        // release samples with the row moving on to row3.
        $display("[TB] key 5");
        base = valid_count;
        exp_q.push_back(4'h5);
        applyStimulus(IDX_KEY5, 1'b1);
        waitValid(100, "key5");
        checkOutput("key5_held", 32'(key_held), 32'd1);
        repeat (200) @(negedge clk);
        checkOutput("key5_still_held", 32'(key_held), 32'd1);
        applyStimulus(IDX_KEY5, 1'b0);
        waitRelease(40, "key5", t);
        checkOutput("key5_release_latency_11_to_14", 32'(t >= 11 && t <= 14), 32'd1);
        checkOutput("key5_row_after_release", 32'(rows_vec), 32'h4);
        @(posedge clk);
        checkOutput("key5_single_pulse", 32'(valid_count - base), 32'd1);

        // Star, sharp and zero.
        $display("[TB] star / sharp / zero");
        exp_q.push_back(4'hA);
        applyStimulus(IDX_STAR, 1'b1);
        waitValid(100, "star");
        checkOutput("star_held", 32'(star_held), 32'd1);
        checkOutput("star_not_sharp", 32'(sharp_held), 32'd0);
        repeat (20) @(negedge clk);
        applyStimulus(IDX_STAR, 1'b0);
        waitRelease(40, "star", t);
        checkOutput("star_held_cleared", 32'(star_held), 32'd0);

        exp_q.push_back(4'hB);
        applyStimulus(IDX_SHARP, 1'b1);
        waitValid(100, "sharp");
        checkOutput("sharp_held", 32'(sharp_held), 32'd1);
        checkOutput("sharp_not_star", 32'(star_held), 32'd0);
        repeat (20) @(negedge clk);
        applyStimulus(IDX_SHARP, 1'b0);
        waitRelease(40, "sharp", t);

        exp_q.push_back(4'h0);
        applyStimulus(IDX_ZERO, 1'b1);
        waitValid(100, "zero");
        checkOutput("zero_code", 32'(key_code), 32'h0);
        repeat (20) @(negedge clk);
        applyStimulus(IDX_ZERO, 1'b0);
        waitRelease(40, "zero", t);

        // One-sample glitch on col3 while row1 is strobed: the candidate is
        // latched (row frozen for one extra dwell), then dropped.
        $display("[TB] col3 glitch");
        base = valid_count;
        waitRow(4'b1000, "glitch_pre");
        waitRow(4'b0001, "glitch_start");
        glitch3 = 1'b1;
        repeat (2) @(negedge clk);
        glitch3 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("glitch_row_frozen", 32'(rows_vec), 32'h1);
        repeat (4) @(negedge clk);
        checkOutput("glitch_row_advanced", 32'(rows_vec), 32'h2);
        checkOutput("glitch_not_held", 32'(key_held), 32'd0);
        repeat (40) @(negedge clk);
        @(posedge clk);
        checkOutput("glitch_no_valid", 32'(valid_count - base), 32'd0);

        // Hold 8, add 9 on the same row, release 8: 9 follows only after.
        $display("[TB] 8 then 9");
        base = valid_count;
        exp_q.push_back(4'h8);
        applyStimulus(IDX_KEY8, 1'b1);
        waitValid(100, "key8");
        applyStimulus(IDX_KEY9, 1'b1);
        repeat (60) @(negedge clk);
        checkOutput("key8_still_held", 32'(key_held), 32'd1);
        checkOutput("key8_code_kept", 32'(key_code), 32'h8);
        @(posedge clk);
        checkOutput("key9_ignored_while_8_held", 32'(valid_count - base), 32'd1);
        @(negedge clk);
        exp_q.push_back(4'h9);
        applyStimulus(IDX_KEY8, 1'b0);
        waitRelease(40, "key8", t);
        waitValid(100, "key9");
        checkOutput("key9_held", 32'(key_held), 32'd1);
        applyStimulus(IDX_KEY9, 1'b0);
        waitRelease(40, "key9", t);

        // Reset while 7 is held, then re-detection after reset.
        $display("[TB] reset during key 7");
        exp_q.push_back(4'h7);
        applyStimulus(IDX_KEY7, 1'b1);
        waitValid(100, "key7");
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_rows", 32'(rows_vec), 32'h1);
        checkOutput("midreset_key_held", 32'(key_held), 32'd0);
        checkOutput("midreset_key_code", 32'(key_code), 32'h0);
        @(negedge clk);
        base = valid_count;
        exp_q.push_back(4'h7);
        reset_n = 1'b1;
        waitValid(100, "key7_again");
        checkOutput("key7_again_code", 32'(key_code), 32'h7);
        applyStimulus(IDX_KEY7, 1'b0);
        waitRelease(40, "key7_again", t);
        @(posedge clk);
        checkOutput("key7_single_redetect", 32'(valid_count - base), 32'd1);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
